shiftreg_op_ctrl: RTL and testbench

- Upstream sequencer for shiftreg_op. Turns one parallel word into a serial bit stream.
- Accepts an N-bit word through a start/ready handshake and captures it.
- Drives shiftreg_op's OP, d and shift_in: one load, then N shifts in the requested direction.
- Samples the shift register's shift_out lines and presents each bit as a qualified serial output, then pulses done.

---
 rtl/shiftreg_pkg.sv | 25 ++
 rtl/shiftreg_op_ctrl_if.sv | 26 ++
 rtl/shiftreg_op.sv | 30 +++
 rtl/shiftreg_op_ctrl.sv | 101 ++++++++++
 tb/tb_shiftreg_op_ctrl.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/shiftreg_pkg.sv
// Shared opcode and sequencer state types for shiftreg_op and its controller.
// No logic, so no latency. No handshake, so no backpressure.
// Also provides the opcode for each shift direction.
package shiftreg_pkg;

    typedef enum logic [1:0] {
        OP_HOLD = 2'b00,
        OP_SHL  = 2'b01,
        OP_SHR  = 2'b10,
        OP_LOAD = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        DONE
    } state_e;

    // dir=0 streams MSB first (shift left), dir=1 streams LSB first (shift right)
    function automatic op_e shift_op(input logic dir);
        return dir ? OP_SHR : OP_SHL;
    endfunction

endpackage

// File: rtl/shiftreg_op_ctrl_if.sv
// Word request handshake plus qualified serial output of the shift sequencer.
// No latency: these are wires only. The slave drops ready while a word is in flight.
// The master side presents words and watches the serial stream.
interface shiftreg_op_ctrl_if #(
    parameter int N = 4
);
    logic         start;
    logic         dir;
    logic         fill;
    logic [N-1:0] data_in;
    logic         ready;
    logic         busy;
    logic         ser_bit;
    logic         ser_valid;
    logic         done;

    modport master (
        output start, dir, fill, data_in,
        input  ready, busy, ser_bit, ser_valid, done
    );

    modport slave (
        input  start, dir, fill, data_in,
        output ready, busy, ser_bit, ser_valid, done
    );
endinterface

// File: rtl/shiftreg_op.sv
// N-bit universal shift register: hold, shift left, shift right or parallel load.
// Latency: the op takes effect at the rising edge of enable. There is no handshake and no backpressure.
// There is no reset, so q keeps its value until the controller issues an op.
module shiftreg_op
    import shiftreg_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         enable,
    input  op_e          OP,
    input  logic [N-1:0] d,
    input  logic         shift_in,
    output logic [N-1:0] q,
    output logic         shift_out_left,
    output logic         shift_out_right
);

    always_ff @(posedge enable) begin
        case (OP)
            OP_SHL:  q <= {q[N-2:0], shift_in};
            OP_SHR:  q <= {shift_in, q[N-1:1]};
            OP_LOAD: q <= d;
            default: q <= q;
        endcase
    end

    assign shift_out_left  = q[N-1];
    assign shift_out_right = q[0];

endmodule

// File: rtl/shiftreg_op_ctrl.sv
// Serializes one N-bit word through shiftreg_op: load once, then N shifts.
// Latency: 2 edges from accept to the first serial bit; each word takes N+2 cycles.
// Backpressure: ready is low while a word is in flight, and start is ignored until ready returns.
module shiftreg_op_ctrl
    import shiftreg_pkg::*;
#(
    parameter int N     = 4,
    parameter int CNT_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic               enable,
    input  logic               rst_n,
    shiftreg_op_ctrl_if.slave  req,
    output op_e                OP,
    output logic [N-1:0]       d,
    output logic               shift_in,
    input  logic               sr_shift_out_left,
    input  logic               sr_shift_out_right
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             dir_q;
    logic             accept;

    always_ff @(posedge enable or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req.start) begin
                    accept  = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD:  state_d = SHIFT;
            SHIFT: begin
                if (cnt_q == LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // Accepting here skips IDLE so back-to-back words stream without a gap
                if (req.start) begin
                    accept  = 1'b1;
                    state_d = LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // OP is registered, so it is set one cycle before the edge where the shift register acts on it
    always_ff @(posedge enable or negedge rst_n) begin
        if (!rst_n) begin
            OP       <= OP_HOLD;
            d        <= '0;
            shift_in <= 1'b0;
            cnt_q    <= '0;
            dir_q    <= 1'b0;
        end else if (accept) begin
            OP       <= OP_LOAD;
            d        <= req.data_in;
            shift_in <= req.fill;
            dir_q    <= req.dir;
        end else begin
            case (state_q)
                LOAD: begin
                    OP    <= shift_op(dir_q);
                    cnt_q <= '0;
                end
                SHIFT: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST) begin
                        OP <= OP_HOLD;
                    end
                end
                default: OP <= OP_HOLD;
            endcase
        end
    end

    assign req.ready     = (state_q == IDLE) || (state_q == DONE);
    assign req.busy      = (state_q == LOAD) || (state_q == SHIFT);
    assign req.ser_valid = (state_q == SHIFT);
    assign req.done      = (state_q == DONE);
    assign req.ser_bit   = dir_q ? sr_shift_out_right : sr_shift_out_left;

endmodule

// File: tb/tb_shiftreg_op_ctrl.sv
// Directed bench for shiftreg_op_ctrl driving a real shiftreg_op.
// Serial bits and final register contents are checked against a scoreboard.
module tb_shiftreg_op_ctrl;
    import shiftreg_pkg::*;

    localparam int N = 4;

    logic         enable = 1'b0;
    logic         rst_n;
    op_e          op;
    logic [N-1:0] d;
    logic         shift_in;
    logic [N-1:0] q;
    logic         sol;
    logic         sor;

    shiftreg_op_ctrl_if #(.N(N)) req_if ();

    shiftreg_op_ctrl #(.N(N)) dut (
        .enable             (enable),
        .rst_n              (rst_n),
        .req                (req_if),
        .OP                 (op),
        .d                  (d),
        .shift_in           (shift_in),
        .sr_shift_out_left  (sol),
        .sr_shift_out_right (sor)
    );

    shiftreg_op #(.N(N)) sr (
        .enable          (enable),
        .OP              (op),
        .d               (d),
        .shift_in        (shift_in),
        .q               (q),
        .shift_out_left  (sol),
        .shift_out_right (sor)
    );

    always #5 enable = ~enable;

    int           checks   = 0;
    int           failures = 0;
    int           cyc      = 0;
    int           done_cnt = 0;
    logic         exp_bits[$];
    logic [N-1:0] exp_q[$];
    int           done_cyc[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(posedge enable) cyc <= cyc + 1;

    // Scoreboard consumer: one serial bit per qualified cycle, final q at each done
    always @(negedge enable) begin
        if (rst_n === 1'b1 && req_if.ser_valid) begin
            if (exp_bits.size() == 0) chk("ser_unexpected", 1, 0);
            else chk("ser_bit", {31'd0, req_if.ser_bit}, {31'd0, exp_bits.pop_front()});
        end
        if (rst_n === 1'b1 && req_if.done) begin
            done_cnt++;
            done_cyc.push_back(cyc);
            chk("done_op", op, OP_HOLD);
            chk("done_ser_valid", req_if.ser_valid, 0);
            if (exp_q.size() == 0) chk("done_unexpected", 1, 0);
            else chk("q_at_done", q, exp_q.pop_front());
        end
    end

    task automatic step();
        @(posedge enable);
        #1;
    endtask

    task automatic push_word(input logic [N-1:0] w, input logic dr, input logic fl,
                             input int nbits, input bit push_q);
        for (int i = 0; i < nbits; i++) exp_bits.push_back(dr ? w[i] : w[N-1-i]);
        if (push_q) exp_q.push_back({N{fl}});
    endtask

    // Presents one word, checks LOAD and the first SHIFT cycle; returns in SHIFT cnt=0
    task automatic send(input logic [N-1:0] w, input logic dr, input logic fl,
                        input int nbits, input bit push_q);
        for (int k = 0; k < 20 && !req_if.ready; k++) step();
        chk("ready_before_send", req_if.ready, 1);
        req_if.data_in = w;
        req_if.dir     = dr;
        req_if.fill    = fl;
        req_if.start   = 1'b1;
        push_word(w, dr, fl, nbits, push_q);
        step();
        req_if.start = 1'b0;
        chk("load_op", op, OP_LOAD);
        chk("load_d", d, w);
        chk("load_busy", req_if.busy, 1);
        chk("load_ready", req_if.ready, 0);
        step();
        chk("shift_op", op, shift_op(dr));
        chk("shift_valid", req_if.ser_valid, 1);
    endtask

    task automatic wait_done(input string tag);
        for (int k = 0; k < 20; k++) begin
            step();
            if (req_if.done) break;
        end
        chk(tag, req_if.done, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] q_snap;
        int           dc;

        rst_n          = 1'b0;
        req_if.start   = 1'b0;
        req_if.dir     = 1'b0;
        req_if.fill    = 1'b0;
        req_if.data_in = '0;
        #1;
        q_snap = q;

        // 1: reset state
        step();
        step();
        chk("rst_op", op, OP_HOLD);
        chk("rst_d", d, 0);
        chk("rst_ready", req_if.ready, 1);
        chk("rst_busy", req_if.busy, 0);
        chk("rst_done", req_if.done, 0);
        chk("rst_valid", req_if.ser_valid, 0);
        chk("rst_q_hold", q, q_snap);
        rst_n = 1'b1;
        step();

        // 2: left, fill 0
        dc = done_cnt;
        send(4'b1010, 1'b0, 1'b0, N, 1'b1);
        wait_done("w2_done");
        step();
        chk("w2_done_pulse", req_if.done, 0);
        chk("w2_done_count", done_cnt, dc + 1);

        // 3: right, fill 0
        send(4'b1010, 1'b1, 1'b0, N, 1'b1);
        wait_done("w3_done");
        step();

        // 4: left, fill 1, with a start attempt while busy
        dc = done_cnt;
        send(4'b1111, 1'b0, 1'b1, N, 1'b1);
        req_if.start   = 1'b1;
        req_if.data_in = 4'b0000;
        step();
        chk("w4_busy_d_hold", d, 4'b1111);
        chk("w4_busy_ready", req_if.ready, 0);
        req_if.start = 1'b0;
        wait_done("w4_done");
        step();
        step();
        step();
        chk("w4_no_extra_done", done_cnt, dc + 1);
        chk("w4_idle_ready", req_if.ready, 1);

        // 5: back-to-back, start held across DONE
        req_if.data_in = 4'b0001;
        req_if.dir     = 1'b0;
        req_if.fill    = 1'b0;
        req_if.start   = 1'b1;
        push_word(4'b0001, 1'b0, 1'b0, N, 1'b1);
        push_word(4'b1000, 1'b0, 1'b0, N, 1'b1);
        step();
        chk("w5a_load_d", d, 4'b0001);
        req_if.data_in = 4'b1000;
        wait_done("w5a_done");
        step();
        req_if.start = 1'b0;
        chk("w5b_direct_load", op, OP_LOAD);
        chk("w5b_load_d", d, 4'b1000);
        wait_done("w5b_done");
        step();
        chk("w5_done_gap", done_cyc[done_cyc.size()-1] - done_cyc[done_cyc.size()-2], N + 2);

        // 6: reset mid-word after two bits
        send(4'b1010, 1'b0, 1'b0, 2, 1'b0);
        step();
        step();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_op", op, OP_HOLD);
        chk("mid_rst_busy", req_if.busy, 0);
        chk("mid_rst_valid", req_if.ser_valid, 0);
        chk("mid_rst_ready", req_if.ready, 1);
        step();
        step();
        rst_n = 1'b1;
        step();
        send(4'b0110, 1'b0, 1'b0, N, 1'b1);
        wait_done("w6_done");
        step();

        chk("bits_left", exp_bits.size(), 0);
        chk("q_left", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
